// File: rtl/core_pipe_wb_pkg.sv
// Shared constants for the writeback stage: load size encodings and FSM states.
// Also provides the byte-offset-to-shift helper used by the load aligner.
package core_pipe_wb_pkg;

  localparam logic [1:0] LSU_B = 2'd0;
  localparam logic [1:0] LSU_H = 2'd1;
  localparam logic [1:0] LSU_W = 2'd2;
  localparam logic [1:0] LSU_D = 2'd3;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_FULL  = 2'd1,
    WB_WAIT  = 2'd2
  } wb_state_e;

  function automatic logic [5:0] byte_shamt(input logic [2:0] boff);
    return {boff, 3'b000};
  endfunction

endpackage

// File: rtl/core_load_align.sv
// Combinational load formatter: shifts the raw doubleword down to the addressed
// byte, keeps the access width and sign- or zero-extends to XLEN.
module core_load_align
  import core_pipe_wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      boff_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> byte_shamt(boff_i);
    data_o  = shifted;
    case (size_i)
      LSU_B:   data_o = {{(XLEN-8){signed_i & shifted[7]}}, shifted[7:0]};
      LSU_H:   data_o = {{(XLEN-16){signed_i & shifted[15]}}, shifted[15:0]};
      LSU_W:   data_o = {{(XLEN-32){signed_i & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/core_pipe_wb.sv
// Writeback stage: single-entry holding register that retires ALU results next
// cycle and loads on their memory response, driving the register file write port.
module core_pipe_wb
  import core_pipe_wb_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_R = 4
) (
  input  logic                  g_clk,
  input  logic                  g_rst,
  input  logic                  s3_valid,
  output logic                  s3_ready,
  input  logic [REG_ADDR_R:0]   s3_rd,
  input  logic [XLEN-1:0]       s3_wdata,
  input  logic                  s3_load,
  input  logic [1:0]            s3_size,
  input  logic                  s3_signed,
  input  logic [2:0]            s3_boff,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rsp_rdata,
  input  logic                  dmem_rsp_error,
  output logic                  rd_wen,
  output logic [REG_ADDR_R:0]   rd_addr,
  output logic [XLEN-1:0]       rd_wdata,
  output logic                  wb_pend,
  output logic [REG_ADDR_R:0]   wb_pend_rd,
  output logic                  trap_load_err,
  output logic                  retire
);

  wb_state_e             state_q, state_d;
  logic [REG_ADDR_R:0]   rd_q, rd_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [2:0]            boff_q, boff_d;
  logic [XLEN-1:0]       load_data;
  logic                  accept;

  core_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i  (dmem_rsp_rdata),
    .boff_i   (boff_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

  // A pending load frees the stage in the same cycle its response arrives.
  assign s3_ready   = (state_q != WB_WAIT) || dmem_rsp_valid;
  assign accept     = s3_valid && s3_ready;
  assign wb_pend    = (state_q == WB_WAIT);
  assign wb_pend_rd = rd_q;
  assign rd_addr    = rd_q;

  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    signed_d      = signed_q;
    boff_d        = boff_q;
    rd_wen        = 1'b0;
    rd_wdata      = wdata_q;
    trap_load_err = 1'b0;
    retire        = 1'b0;

    case (state_q)
      WB_FULL: begin
        rd_wen  = (rd_q != '0);
        retire  = 1'b1;
        state_d = WB_EMPTY;
      end
      WB_WAIT: begin
        if (dmem_rsp_valid) begin
          retire  = 1'b1;
          state_d = WB_EMPTY;
          if (dmem_rsp_error) begin
            trap_load_err = 1'b1;
          end else begin
            rd_wen   = (rd_q != '0);
            rd_wdata = load_data;
          end
        end
      end
      default: state_d = WB_EMPTY;
    endcase

    if (accept) begin
      rd_d     = s3_rd;
      wdata_d  = s3_wdata;
      size_d   = s3_size;
      signed_d = s3_signed;
      boff_d   = s3_boff;
      state_d  = s3_load ? WB_WAIT : WB_FULL;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      state_q  <= WB_EMPTY;
      rd_q     <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      boff_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      boff_q   <= boff_d;
    end
  end

  a_no_stray_rsp : assert property (@(posedge g_clk) disable iff (g_rst)
    !(dmem_rsp_valid && (state_q != WB_WAIT)))
    else $error("dmem response received with no load outstanding");

endmodule

// File: tb/tb_core_pipe_wb.sv
// Directed table-driven bench for the writeback stage plus a reset-during-load sequence.
module tb_core_pipe_wb;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        s3_valid;
  logic        s3_ready;
  logic [4:0]  s3_rd;
  logic [63:0] s3_wdata;
  logic        s3_load;
  logic [1:0]  s3_size;
  logic        s3_signed;
  logic [2:0]  s3_boff;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        dmem_rsp_error;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [63:0] rd_wdata;
  logic        wb_pend;
  logic [4:0]  wb_pend_rd;
  logic        trap_load_err;
  logic        retire;

  always #5 g_clk = ~g_clk;

  core_pipe_wb #(.XLEN(64), .REG_ADDR_R(4)) dut (
    .g_clk          (g_clk),
    .g_rst          (g_rst),
    .s3_valid       (s3_valid),
    .s3_ready       (s3_ready),
    .s3_rd          (s3_rd),
    .s3_wdata       (s3_wdata),
    .s3_load        (s3_load),
    .s3_size        (s3_size),
    .s3_signed      (s3_signed),
    .s3_boff        (s3_boff),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .dmem_rsp_error (dmem_rsp_error),
    .rd_wen         (rd_wen),
    .rd_addr        (rd_addr),
    .rd_wdata       (rd_wdata),
    .wb_pend        (wb_pend),
    .wb_pend_rd     (wb_pend_rd),
    .trap_load_err  (trap_load_err),
    .retire         (retire)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic        ld;
    logic [1:0]  sz;
    logic        sg;
    logic [2:0]  bo;
    logic        rv;
    logic [63:0] rdat;
    logic        er;
  } stim_t;

  typedef struct {
    logic        rdy;
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] wdat;
    logic        pend;
    logic [4:0]  prd;
    logic        trap;
    logic        ret;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic stim_t mk_s(logic v, logic [4:0] rd, logic [63:0] wd, logic ld,
                                 logic [1:0] sz, logic sg, logic [2:0] bo,
                                 logic rv, logic [63:0] rdat, logic er);
    stim_t s;
    s.v = v; s.rd = rd; s.wd = wd; s.ld = ld; s.sz = sz; s.sg = sg; s.bo = bo;
    s.rv = rv; s.rdat = rdat; s.er = er;
    return s;
  endfunction

  function automatic stim_t s_idle();
    return mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic stim_t s_alu(logic [4:0] rd, logic [63:0] wd);
    return mk_s(1, rd, wd, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic stim_t s_ld(logic [4:0] rd, logic [1:0] sz, logic sg, logic [2:0] bo);
    return mk_s(1, rd, 64'h0, 1, sz, sg, bo, 0, 0, 0);
  endfunction
  function automatic stim_t s_rsp(logic [63:0] rdat, logic er);
    return mk_s(0, 0, 0, 0, 0, 0, 0, 1, rdat, er);
  endfunction

  function automatic exp_t mk_e(logic rdy, logic wen, logic [4:0] addr, logic [63:0] wdat,
                                logic pend, logic [4:0] prd, logic trap, logic ret);
    exp_t e;
    e.rdy = rdy; e.wen = wen; e.addr = addr; e.wdat = wdat;
    e.pend = pend; e.prd = prd; e.trap = trap; e.ret = ret;
    return e;
  endfunction

  // Idle EMPTY with a given held rd; WAIT with no response.
  function automatic exp_t e_empty(logic [4:0] rd);
    return mk_e(1, 0, rd, 0, 0, rd, 0, 0);
  endfunction
  function automatic exp_t e_wait(logic [4:0] rd);
    return mk_e(0, 0, rd, 0, 1, rd, 0, 0);
  endfunction

  function automatic void add(stim_t s, exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(stim_t s);
    s3_valid       = s.v;
    s3_rd          = s.rd;
    s3_wdata       = s.wd;
    s3_load        = s.ld;
    s3_size        = s.sz;
    s3_signed      = s.sg;
    s3_boff        = s.bo;
    dmem_rsp_valid = s.rv;
    dmem_rsp_rdata = s.rdat;
    dmem_rsp_error = s.er;
  endtask

  // rd_wdata is only meaningful when a write is expected, so it is masked otherwise.
  task automatic check(string name, exp_t e);
    logic [79:0] act, exp;
    act = {s3_ready, rd_wen, rd_addr, (e.wen ? rd_wdata : 64'h0), wb_pend, wb_pend_rd,
           trap_load_err, retire};
    exp = {e.rdy, e.wen, e.addr, (e.wen ? e.wdat : 64'h0), e.pend, e.prd, e.trap, e.ret};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy=%b wen=%b addr=%0d wdata=%h pend=%b prd=%0d trap=%b ret=%b, want rdy=%b wen=%b addr=%0d wdata=%h pend=%b prd=%0d trap=%b ret=%b",
               name, s3_ready, rd_wen, rd_addr, rd_wdata, wb_pend, wb_pend_rd, trap_load_err, retire,
               e.rdy, e.wen, e.addr, e.wdat, e.pend, e.prd, e.trap, e.ret);
    end
  endtask

  initial begin
    // ALU write, then x0 suppression
    add(s_alu(5, 64'h1234),  e_empty(0));
    add(s_idle(),            mk_e(1, 1, 5, 64'h1234, 0, 5, 0, 1));
    add(s_idle(),            e_empty(5));
    add(s_alu(0, 64'hFFFF),  e_empty(5));
    add(s_idle(),            mk_e(1, 0, 0, 0, 0, 0, 0, 1));
    // Signed byte load, response after 4 waiting cycles
    add(s_ld(7, 2'd0, 1, 3), e_empty(0));
    for (int i = 0; i < 4; i++) add(s_idle(), e_wait(7));
    add(s_rsp(64'h00000000_80000000, 0), mk_e(1, 1, 7, 64'hFFFFFFFF_FFFFFF80, 1, 7, 0, 1));
    add(s_idle(),            e_empty(7));
    // Unsigned half load at offset 6
    add(s_ld(9, 2'd1, 0, 6), e_empty(7));
    add(s_rsp(64'hBEEF0000_00000000, 0), mk_e(1, 1, 9, 64'h00000000_0000BEEF, 1, 9, 0, 1));
    // Back-to-back: signed word load completes while an ALU op is accepted
    add(s_ld(3, 2'd2, 1, 4), e_empty(9));
    add(mk_s(1, 4, 64'hABCD, 0, 0, 0, 0, 1, 64'hF0000001_00000000, 0),
        mk_e(1, 1, 3, 64'hFFFFFFFF_F0000001, 1, 3, 0, 1));
    add(s_idle(),            mk_e(1, 1, 4, 64'hABCD, 0, 4, 0, 1));
    // Bus error on a doubleword load
    add(s_ld(10, 2'd3, 1, 0), e_empty(4));
    add(s_rsp(64'h1234, 1),  mk_e(1, 0, 10, 0, 1, 10, 1, 1));
    add(s_idle(),            e_empty(10));
    // Doubleword load ignores signed
    add(s_ld(12, 2'd3, 1, 0), e_empty(10));
    add(s_rsp(64'h80000000_00000001, 0), mk_e(1, 1, 12, 64'h80000000_00000001, 1, 12, 0, 1));
    // Unsigned byte at the top offset
    add(s_ld(13, 2'd0, 0, 7), e_empty(12));
    add(s_rsp(64'hA5000000_00000000, 0), mk_e(1, 1, 13, 64'h00000000_000000A5, 1, 13, 0, 1));
    // Signed half at offset 2
    add(s_ld(14, 2'd1, 1, 2), e_empty(13));
    add(s_rsp(64'h00000000_80010000, 0), mk_e(1, 1, 14, 64'hFFFFFFFF_FFFF8001, 1, 14, 0, 1));
    add(s_idle(),            e_empty(14));

    g_rst = 1'b1;
    drive(s_idle());
    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    #1 check("reset_state", e_empty(0));

    g_rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge g_clk);
      drive(tbl[i].s);
      #1 check($sformatf("row%0d", i), tbl[i].e);
    end

    // Reset while a load is pending; the late response must not write.
    @(negedge g_clk);
    drive(s_ld(6, 2'd0, 0, 0));
    #1 check("rst_seq_accept", e_empty(14));
    @(negedge g_clk);
    drive(s_idle());
    #1 check("rst_seq_wait", e_wait(6));
    g_rst = 1'b1;
    @(negedge g_clk);
    drive(s_rsp(64'hFFFF_FFFF_FFFF_FFFF, 0));
    #1 check("rst_seq_dropped", e_empty(0));
    @(negedge g_clk);
    g_rst = 1'b0;
    drive(s_idle());
    #1 check("rst_seq_after", e_empty(0));

    @(negedge g_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
